// File: rtl/mem_bus_pkg.sv
// Shared constants for the memory-side bus responder: region codes, timer state, ctrl/status bits.
package mem_bus_pkg;

    localparam int unsigned REGION_W = 4;
    localparam int unsigned SW_W     = 10;
    localparam int unsigned LED_W    = 10;

    localparam logic [REGION_W-1:0] REG_RAM   = 4'h0;
    localparam logic [REGION_W-1:0] REG_LEDR  = 4'h1;
    localparam logic [REGION_W-1:0] REG_SW    = 4'h3;
    localparam logic [REGION_W-1:0] REG_TIMER = 4'h4;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_RUN     = 2'd1,
        T_EXPIRED = 2'd2
    } timer_state_e;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_CLEAR   = 1;
    localparam int unsigned STAT_RUNNING = 0;
    localparam int unsigned STAT_EXPIRED = 1;

endpackage

// File: rtl/mem_bus_responder_if.sv
// Processor address/data bus: the core drives addr/dout/w, the responder returns din.
interface mem_bus_responder_if
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              w;
    logic [DATA_W-1:0] din;

    modport master (output addr, output dout, output w, input din);
    modport slave  (input addr, input dout, input w, output din);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped interval timer: prescaler, down-counter with reload, IDLE/RUN/EXPIRED FSM.
// Only instantiated when MEM_BUS_TIMER_EN is defined.
module bus_timer
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_we_i,
    input  logic              cnt_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              running_o,
    output logic              expired_o,
    output logic [DATA_W-1:0] count_o
);
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    timer_state_e      state_q;
    logic [PS_W-1:0]   ps_q;
    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] reload_q;
    logic              running_q;
    logic              expired_q;

    // Ctrl writes take priority over a coincident tick; clear beats start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= T_IDLE;
            ps_q      <= '0;
            count_q   <= '0;
            reload_q  <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            if (cnt_we_i) begin
                reload_q <= wdata_i;
            end
            if (ctrl_we_i && wdata_i[CTRL_CLEAR]) begin
                state_q   <= T_IDLE;
                running_q <= 1'b0;
                expired_q <= 1'b0;
            end else if (ctrl_we_i && wdata_i[CTRL_START]) begin
                state_q   <= T_RUN;
                count_q   <= reload_q;
                ps_q      <= '0;
                running_q <= 1'b1;
                expired_q <= 1'b0;
            end else if (state_q == T_RUN) begin
                if (ps_q == PS_LAST) begin
                    ps_q <= '0;
                    if (count_q == '0) begin
                        state_q   <= T_EXPIRED;
                        running_q <= 1'b0;
                        expired_q <= 1'b1;
                    end else begin
                        count_q <= count_q - DATA_W'(1);
                    end
                end else begin
                    ps_q <= ps_q + PS_W'(1);
                end
            end
        end
    end

    assign running_o = running_q;
    assign expired_o = expired_q;
    assign count_o   = count_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: RAM, LEDR, synchronized switches and (with MEM_BUS_TIMER_EN) an
// interval timer, with a fixed one-cycle registered read path and zero wait states.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned RAM_AW         = 8,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMER_PRESCALE = 50000
) (
    input  logic                clk,
    input  logic                reset,
    mem_bus_responder_if.slave  bus,
    input  logic [SW_W-1:0]     sw_i,
    output logic [LED_W-1:0]    ledr_o
);
    localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;

    logic [REGION_W-1:0] region_c;
    logic [RAM_AW-1:0]   ram_addr_c;
    logic                ram_we_c;
    logic                led_we_c;
    logic [DATA_W-1:0]   timer_rd_c;
    logic                unused_addr_c;

    logic [DATA_W-1:0]   mem_q [RAM_DEPTH];
    logic [LED_W-1:0]    ledr_q;
    logic [SW_W-1:0]     sw_meta_q;
    logic [SW_W-1:0]     sw_sync_q;
    logic [DATA_W-1:0]   din_q;
    logic [DATA_W-1:0]   din_d;

    assign region_c      = bus.addr[ADDR_W-1 -: REGION_W];
    assign ram_addr_c    = bus.addr[RAM_AW-1:0];
    assign ram_we_c      = bus.w && (region_c == REG_RAM);
    assign led_we_c      = bus.w && (region_c == REG_LEDR);
    // Address bits between the RAM index and the region field alias within a region.
    assign unused_addr_c = ^bus.addr[ADDR_W-REGION_W-1:RAM_AW];

`ifdef MEM_BUS_TIMER_EN
    logic              timer_ctrl_we_c;
    logic              timer_cnt_we_c;
    logic              timer_running;
    logic              timer_expired;
    logic [DATA_W-1:0] timer_count;

    assign timer_ctrl_we_c = bus.w && (region_c == REG_TIMER) && !bus.addr[0];
    assign timer_cnt_we_c  = bus.w && (region_c == REG_TIMER) &&  bus.addr[0];

    bus_timer #(
        .DATA_W   (DATA_W),
        .PRESCALE (TIMER_PRESCALE)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .ctrl_we_i (timer_ctrl_we_c),
        .cnt_we_i  (timer_cnt_we_c),
        .wdata_i   (bus.dout),
        .running_o (timer_running),
        .expired_o (timer_expired),
        .count_o   (timer_count)
    );

    always_comb begin
        timer_rd_c = '0;
        if (bus.addr[0]) begin
            timer_rd_c = timer_count;
        end else begin
            timer_rd_c[STAT_RUNNING] = timer_running;
            timer_rd_c[STAT_EXPIRED] = timer_expired;
        end
    end
`else
    localparam int unsigned unused_prescale = TIMER_PRESCALE;
    assign timer_rd_c = '0;
`endif

    // RAM has no reset; reads below see the pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            mem_q[ram_addr_c] <= bus.dout;
        end
    end

    always_comb begin
        din_d = '0;
        case (region_c)
            REG_RAM:   din_d = mem_q[ram_addr_c];
            REG_LEDR:  din_d = DATA_W'(ledr_q);
            REG_SW:    din_d = DATA_W'(sw_sync_q);
            REG_TIMER: din_d = timer_rd_c;
            default:   din_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ledr_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            din_q     <= '0;
        end else begin
            if (led_we_c) begin
                ledr_q <= bus.dout[LED_W-1:0];
            end
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
            din_q     <= din_d;
        end
    end

    assign bus.din = din_q;
    assign ledr_o  = ledr_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed scenarios then random bus traffic against a cycle-count model.
module tb_mem_bus_responder;
    import mem_bus_pkg::*;

    localparam int unsigned RAM_AW   = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned PRESCALE = 4;

    logic       clk;
    logic       reset;
    logic [9:0] sw_i;
    logic [9:0] ledr_o;

    int checks   = 0;
    int failures = 0;

    mem_bus_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_responder #(
        .RAM_AW         (RAM_AW),
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .TIMER_PRESCALE (PRESCALE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .sw_i   (sw_i),
        .ledr_o (ledr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: RAM image with validity, LED value, switch history, timer as start-time arithmetic.
    logic [15:0] m_ram [256];
    bit          m_val [256] = '{default: 1'b0};
    logic [9:0]  m_led;
    logic [9:0]  sw_old;
    logic [9:0]  sw_new;
    int unsigned sw_chg;
    int unsigned cyc = 0;

`ifdef MEM_BUS_TIMER_EN
    int          t_mode;
    int unsigned t_start;
    int unsigned t_base;
    logic [15:0] t_held;
    logic [15:0] t_reload;

    task automatic t_view(input int unsigned c, output logic r, output logic x, output logic [15:0] n);
        int unsigned ticks;
        if (t_mode == 0) begin
            r = 1'b0; x = 1'b0; n = t_held;
        end else begin
            ticks = (c - t_start) / PRESCALE;
            if (ticks > t_base) begin
                r = 1'b0; x = 1'b1; n = 16'h0000;
            end else begin
                r = 1'b1; x = 1'b0; n = 16'(t_base - ticks);
            end
        end
    endtask
`endif

    function automatic logic [9:0] sw_seen(input int unsigned c);
        return (c >= sw_chg + 2) ? sw_new : sw_old;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_read(input logic [15:0] a, input int unsigned c,
                              output logic [15:0] e, output bit ev);
`ifdef MEM_BUS_TIMER_EN
        logic r, x;
        logic [15:0] n;
`endif
        ev = 1'b1;
        e  = 16'h0000;
        case (a[15:12])
            REG_RAM:  begin ev = m_val[a[7:0]]; e = m_ram[a[7:0]]; end
            REG_LEDR: ev = 1'b0;
            REG_SW:   e = 16'(sw_seen(c));
            REG_TIMER: begin
`ifdef MEM_BUS_TIMER_EN
                t_view(c, r, x, n);
                e = a[0] ? n : {14'b0, x, r};
`endif
            end
            default:  e = 16'h0000;
        endcase
    endtask

    task automatic model_write(input logic [15:0] a, input logic [15:0] d, input int unsigned c);
`ifdef MEM_BUS_TIMER_EN
        logic r, x;
        logic [15:0] n;
`endif
        case (a[15:12])
            REG_RAM:  begin m_ram[a[7:0]] = d; m_val[a[7:0]] = 1'b1; end
            REG_LEDR: m_led = d[9:0];
            REG_TIMER: begin
`ifdef MEM_BUS_TIMER_EN
                if (a[0]) begin
                    t_reload = d;
                end else if (d[CTRL_CLEAR]) begin
                    t_view(c, r, x, n);
                    t_held = n;
                    t_mode = 0;
                end else if (d[CTRL_START]) begin
                    t_mode  = 1;
                    t_start = c + 1;
                    t_base  = int'(t_reload);
                end
`endif
            end
            default: ;
        endcase
    endtask

    task automatic set_sw(input logic [9:0] v);
        sw_old = sw_seen(cyc);
        sw_new = v;
        sw_chg = cyc;
        sw_i   = v;
    endtask

    // One bus cycle: drive, clock, then compare din (read of this cycle's addr) and ledr.
    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w);
        logic [15:0] e;
        bit          ev;
        bus.addr = a;
        bus.dout = d;
        bus.w    = w;
        model_read(a, cyc, e, ev);
        @(posedge clk);
        #1;
        if (w) model_write(a, d, cyc);
        cyc++;
        if (ev) chk($sformatf("din@%h", a), bus.din, e);
        chk("ledr", 16'(ledr_o), 16'(m_led));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.w    = 1'b0;
        bus.addr = 16'h7000;
        bus.dout = 16'h0000;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_led  = '0;
        sw_old = '0;
        sw_new = sw_i;
        sw_chg = cyc + 1;
`ifdef MEM_BUS_TIMER_EN
        t_mode   = 0;
        t_held   = 16'h0000;
        t_reload = 16'h0000;
`endif
        cyc++;
        chk("reset_din", bus.din, 16'h0000);
        chk("reset_ledr", 16'(ledr_o), 16'h0000);
    endtask

    initial begin
        reset    = 1'b1;
        sw_i     = '0;
        bus.addr = '0;
        bus.dout = '0;
        bus.w    = 1'b0;

        // 1: reset, RAM write then read back
        do_reset();
        step(16'h0005, 16'hBEEF, 1'b1);
        step(16'h0005, 16'h0000, 1'b0);
        chk("t1_ram_read", bus.din, 16'hBEEF);

        // 2: same-cycle write and read returns old value
        step(16'h0005, 16'h1234, 1'b1);
        chk("t2_read_first", bus.din, 16'hBEEF);
        step(16'h0005, 16'h0000, 1'b0);
        chk("t2_new_value", bus.din, 16'h1234);

        // 3: LEDR write, unmapped read/write
        step(16'h1000, 16'h03FF, 1'b1);
        chk("t3_ledr", 16'(ledr_o), 16'h03FF);
        step(16'h7000, 16'h0000, 1'b0);
        chk("t3_unmapped_read", bus.din, 16'h0000);
        step(16'h7005, 16'hDEAD, 1'b1);
        chk("t3_unmapped_ledr", 16'(ledr_o), 16'h03FF);
        step(16'h0005, 16'h0000, 1'b0);
        chk("t3_no_alias", bus.din, 16'h1234);

        // 4: switch synchronizer lag
        set_sw(10'h2A5);
        for (int i = 0; i < 5; i++) step(16'h3000, 16'hFFFF, 1'b1);
        chk("t4_sw", bus.din, 16'h02A5);

`ifdef MEM_BUS_TIMER_EN
        // 5: reload 2, run to expiry
        step(16'h4001, 16'h0002, 1'b1);
        step(16'h4000, 16'h0001, 1'b1);
        chk("t5_idle_before_start", bus.din, 16'h0000);
        for (int i = 0; i < 14; i++) step((i % 2 == 0) ? 16'h4001 : 16'h4000, 16'h0000, 1'b0);
        step(16'h4000, 16'h0000, 1'b0);
        chk("t5_expired_status", bus.din, 16'h0002);
        step(16'h4001, 16'h0000, 1'b0);
        chk("t5_expired_count", bus.din, 16'h0000);

        // 6: start+clear together, then reset mid-run
        step(16'h4000, 16'h0001, 1'b1);
        for (int i = 0; i < 5; i++) step(16'h4001, 16'h0000, 1'b0);
        step(16'h4000, 16'h0003, 1'b1);
        step(16'h4000, 16'h0000, 1'b0);
        chk("t6_clear_wins", bus.din, 16'h0000);
        step(16'h4001, 16'h0000, 1'b0);
        chk("t6_count_held", bus.din, 16'h0001);
        step(16'h4000, 16'h0001, 1'b1);
        step(16'h4000, 16'h0000, 1'b0);
        chk("t6_running", bus.din, 16'h0001);
        do_reset();
        step(16'h4001, 16'h0000, 1'b0);
        chk("t6_reset_count", bus.din, 16'h0000);
        step(16'h4000, 16'h0000, 1'b0);
        chk("t6_reset_status", bus.din, 16'h0000);
`else
        // 6: timer region is unmapped in this build
        step(16'h4001, 16'h0055, 1'b1);
        step(16'h4000, 16'h0001, 1'b1);
        step(16'h4001, 16'h0000, 1'b0);
        chk("t6_no_timer_count", bus.din, 16'h0000);
        step(16'h4000, 16'h0000, 1'b0);
        chk("t6_no_timer_status", bus.din, 16'h0000);
`endif

        // Random traffic across all regions
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            logic [15:0] d;
            logic        w;
            int          r;
            int          rg;
            r = int'($urandom_range(0, 9));
            if (r <= 3)      a = {4'h0, 4'($urandom), 4'h0, 4'($urandom)};
            else if (r == 4) a = {4'h1, 12'($urandom)};
            else if (r == 5) a = {4'h3, 12'($urandom)};
            else if (r <= 7) a = {4'h4, 12'($urandom)};
            else begin
                rg = int'($urandom_range(5, 16));
                a  = {(rg == 16) ? 4'h2 : 4'(rg), 12'($urandom)};
            end
            w = ($urandom_range(0, 2) == 0);
            d = 16'($urandom);
            if (a[15:12] == 4'h4 && a[0]) d = 16'($urandom_range(0, 3));
            if (cyc >= sw_chg + 2 && $urandom_range(0, 7) == 0) set_sw(10'($urandom));
            if (n == 200) do_reset();
            step(a, d, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
